// File: rtl/fc_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_scheduler
// Function : start sequencing and status for a chain of concurrently running
//            FC layers. Optional watchdog: define FC_SCHED_WDOG_EN.
// Revision : 1.0
// ============================================================================
module fc_layer_scheduler #(
  parameter int NUM_LAYERS  = 3,
  parameter int FRAME_CNT_W = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   network_enable,
  input  logic                   pipeline_reset,
  input  logic [NUM_LAYERS-1:0]  src_empty,
  input  logic [NUM_LAYERS-1:0]  sink_full,
  input  logic [NUM_LAYERS-1:0]  layer_busy,
  input  logic [NUM_LAYERS-1:0]  layer_done,
  output logic [NUM_LAYERS-1:0]  layer_start,
  output logic                   pipeline_busy,
  output logic                   pipeline_stalled,
  output logic                   pipeline_ready,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic [NUM_LAYERS-1:0]  wdog_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                 state     [NUM_LAYERS];
  state_t                 state_nxt [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]  start_r;
  logic [NUM_LAYERS-1:0]  active;
  logic [NUM_LAYERS-1:0]  can_start;
  logic [NUM_LAYERS-1:0]  stall_vec;
  logic [NUM_LAYERS-1:0]  timeout;
  logic [FRAME_CNT_W-1:0] frames_r;

  if (WDOG_CYCLES < 2) begin : g_wdog_param_check
    $error("fc_layer_scheduler: WDOG_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    assign active[i]    = (state[i] != S_IDLE);
    assign can_start[i] = network_enable & ~src_empty[i] & ~sink_full[i] & ~layer_busy[i];
    assign stall_vec[i] = ~active[i] & ~src_empty[i] & sink_full[i];
  end

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        S_IDLE:  if (can_start[i]) state_nxt[i] = S_ARMED;
        // a done that beats busy still ends the run
        S_ARMED: begin
          if (layer_done[i])      state_nxt[i] = S_IDLE;
          else if (layer_busy[i]) state_nxt[i] = S_RUN;
        end
        S_RUN:   if (layer_done[i]) state_nxt[i] = S_IDLE;
        default: state_nxt[i] = S_IDLE;
      endcase
      if (pipeline_reset || timeout[i]) state_nxt[i] = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) state[i] <= S_IDLE;
      start_r  <= '0;
      frames_r <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        state[i]   <= state_nxt[i];
        start_r[i] <= (state[i] == S_IDLE) && (state_nxt[i] == S_ARMED);
      end
      if (pipeline_reset)
        frames_r <= '0;
      else if (layer_done[NUM_LAYERS-1] && active[NUM_LAYERS-1])
        frames_r <= frames_r + FRAME_CNT_W'(1);
    end
  end

`ifdef FC_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0]     wdog_cnt [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] wdog_err_r;

  // a layer may stay out of IDLE for exactly WDOG_CYCLES cycles
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_wdog
    assign timeout[i] = active[i] && (wdog_cnt[i] == WDOG_W'(WDOG_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) wdog_cnt[i] <= '0;
      wdog_err_r <= '0;
    end else if (pipeline_reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) wdog_cnt[i] <= '0;
      wdog_err_r <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (!active[i] || timeout[i]) wdog_cnt[i] <= '0;
        else                          wdog_cnt[i] <= wdog_cnt[i] + WDOG_W'(1);
        if (timeout[i]) wdog_err_r[i] <= 1'b1;
      end
    end
  end

  assign wdog_err = wdog_err_r;
`else
  assign timeout  = '0;
  assign wdog_err = '0;
`endif

  assign layer_start      = start_r;
  assign frames_done      = frames_r;
  assign pipeline_busy    = |active;
  // status is held low while the async reset is asserted
  assign pipeline_stalled = ~rst & network_enable & (|stall_vec);
  assign pipeline_ready   = ~rst & network_enable & ~pipeline_reset & ~pipeline_busy;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_scheduler.sv
`default_nettype none
// Directed bench for fc_layer_scheduler: start pulses tracked through a scoreboard
// queue, status outputs compared against bench-held expectations.
module tb_fc_layer_scheduler;

  localparam int N = 3;
  localparam int FW = 16;
`ifdef FC_SCHED_WDOG_EN
  localparam int BUSY_CYC = 5;
`else
  localparam int BUSY_CYC = 10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          network_enable;
  logic          pipeline_reset;
  logic [N-1:0]  src_empty, sink_full, layer_busy, layer_done;
  logic [N-1:0]  layer_start, wdog_err;
  logic          pipeline_busy, pipeline_stalled, pipeline_ready;
  logic [FW-1:0] frames_done;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  logic [N-1:0] exp_start_q[$];

  fc_layer_scheduler #(.NUM_LAYERS(N), .FRAME_CNT_W(FW), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .network_enable(network_enable), .pipeline_reset(pipeline_reset),
    .src_empty(src_empty), .sink_full(sink_full), .layer_busy(layer_busy), .layer_done(layer_done),
    .layer_start(layer_start), .pipeline_busy(pipeline_busy), .pipeline_stalled(pipeline_stalled),
    .pipeline_ready(pipeline_ready), .frames_done(frames_done), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every nonzero start vector must match the next expected one, exactly once
  always @(negedge clk) begin
    if (layer_start !== '0) begin
      checks++;
      if (rst) begin
        errors++;
        $error("FAIL start_in_reset: observed %b expected 000", layer_start);
      end else if (exp_start_q.size() == 0) begin
        errors++;
        $error("FAIL start_unexpected: observed %b expected none", layer_start);
      end else begin
        logic [N-1:0] e;
        e = exp_start_q.pop_front();
        assert (layer_start === e) else begin
          errors++;
          $error("FAIL start_pulse: observed %b expected %b", layer_start, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: observed timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; network_enable = 1'b0; pipeline_reset = 1'b0;
    src_empty = '1; sink_full = '0; layer_busy = '0; layer_done = '0;
    tick(); tick();
    chk("rst_start", layer_start, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_busy", pipeline_busy, 0);
    chk("rst_stalled", pipeline_stalled, 0);
    chk("rst_ready", pipeline_ready, 0);
    chk("rst_wdog", wdog_err, 0);
    rst = 1'b0;
    tick();

    // single frame through layer 0
    network_enable = 1'b1;
    #1 chk("ready_idle", pipeline_ready, 1);
    src_empty = 3'b110;
    exp_start_q.push_back(3'b001);
    tick();
    chk("armed_busy", pipeline_busy, 1);
    chk("armed_ready", pipeline_ready, 0);
    src_empty = 3'b111; layer_busy = 3'b001;
    repeat (BUSY_CYC) tick();
    chk("run_busy", pipeline_busy, 1);
    layer_busy = 3'b000; layer_done = 3'b001;
    tick();
    layer_done = 3'b000;
    chk("done_idle", pipeline_busy, 0);
    chk("done_ready", pipeline_ready, 1);
    chk("l0_no_frame", frames_done, 0);

    // back-pressure on the output FIFO
    src_empty = 3'b011; sink_full = 3'b100;
    tick(); tick();
    chk("bp_stalled", pipeline_stalled, 1);
    chk("bp_no_start", pipeline_busy, 0);
    sink_full = 3'b000;
    exp_start_q.push_back(3'b100);
    #1 chk("bp_release_stalled", pipeline_stalled, 0);
    tick();
    src_empty = 3'b111; layer_busy = 3'b100;
    tick();
    layer_busy = 3'b000; layer_done = 3'b100; exp_frames++;
    tick();
    layer_done = 3'b000;
    chk("bp_frames", frames_done, exp_frames);
    chk("bp_q_empty", exp_start_q.size(), 0);

    // concurrency: all three start together
    src_empty = 3'b000;
    exp_start_q.push_back(3'b111);
    tick();
    src_empty = 3'b111; layer_busy = 3'b111;
    tick();
    chk("conc_busy", pipeline_busy, 1);
    layer_busy = 3'b000; layer_done = 3'b111; exp_frames++;
    tick();
    layer_done = 3'b000;
    for (int r = 0; r < 2; r++) begin
      src_empty = 3'b011;
      exp_start_q.push_back(3'b100);
      tick();
      src_empty = 3'b111; layer_busy = 3'b100;
      tick();
      layer_busy = 3'b000; layer_done = 3'b100; exp_frames++;
      tick();
      layer_done = 3'b000;
    end
    chk("conc_frames", frames_done, exp_frames);
    layer_done = 3'b100;
    tick();
    layer_done = 3'b000;
    chk("spurious_done", frames_done, exp_frames);

    // flush during RUN on all layers
    src_empty = 3'b000;
    exp_start_q.push_back(3'b111);
    tick();
    src_empty = 3'b111; layer_busy = 3'b111;
    tick();
    pipeline_reset = 1'b1; layer_busy = 3'b000; src_empty = 3'b000;
    tick();
    exp_frames = 0;
    chk("flush_busy", pipeline_busy, 0);
    chk("flush_frames", frames_done, exp_frames);
    chk("flush_ready", pipeline_ready, 0);
    pipeline_reset = 1'b0; src_empty = 3'b111; layer_done = 3'b100;
    tick();
    layer_done = 3'b000;
    chk("post_flush_done", frames_done, exp_frames);
    chk("post_flush_idle", pipeline_busy, 0);

    // enable gates new starts only
    network_enable = 1'b0; src_empty = 3'b110;
    tick(); tick();
    chk("dis_no_start", pipeline_busy, 0);
    chk("dis_ready", pipeline_ready, 0);

    // watchdog: layer 0 stays busy forever
    network_enable = 1'b1;
    exp_start_q.push_back(3'b001);
    tick();
    src_empty = 3'b111; layer_busy = 3'b001;
    repeat (5) tick();
    chk("wd_early_err", wdog_err, 0);
    chk("wd_early_busy", pipeline_busy, 1);
    repeat (7) tick();
`ifdef FC_SCHED_WDOG_EN
    chk("wd_err", wdog_err, 3'b001);
    chk("wd_idle", pipeline_busy, 0);
`else
    chk("wd_off_err", wdog_err, 0);
    chk("wd_off_run", pipeline_busy, 1);
`endif
    pipeline_reset = 1'b1;
    tick();
    pipeline_reset = 1'b0; layer_busy = 3'b000;
    chk("wd_clear", wdog_err, 0);

    // async reset in the middle of a run
    src_empty = 3'b110;
    exp_start_q.push_back(3'b001);
    tick();
    src_empty = 3'b111; layer_busy = 3'b001;
    tick(); tick();
    layer_done = 3'b100;
    #2 rst = 1'b1;
    src_empty = 3'b000; layer_busy = 3'b000; layer_done = 3'b000;
    #1;
    chk("mid_rst_start", layer_start, 0);
    chk("mid_rst_busy", pipeline_busy, 0);
    chk("mid_rst_ready", pipeline_ready, 0);
    chk("mid_rst_frames", frames_done, 0);
    tick(); tick(); tick();
    chk("hold_rst_start", layer_start, 0);
    src_empty = 3'b111;
    rst = 1'b0;
    tick(); tick();
    chk("final_q_empty", exp_start_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
